iot_stream_filter: RTL and testbench

- Parametrised successor of the team's IoT data filter.
- Assembles a byte stream into DATA_BYTES-wide items and groups the items into rounds of ROUND items.
- Applies one of seven filter functions per round: max, min, average, range extract, range exclude, peak-max and peak-min.
- Adds run-time thresholds and output back-pressure through a one-entry output holding register. Sits between the sensor byte interface and the downstream packet sink.

---
 rtl/iot_stream_filter.sv | 214 +++++++++++++++++++++
 tb/tb_iot_stream_filter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iot_stream_filter.sv
// Byte-stream filter: assembles DATA_BYTES-beat items into rounds of ROUND items and
// applies a selectable per-round reduction or per-item threshold/peak filter.
module iot_stream_filter #(
   parameter int BYTE_W     = 8,
   parameter int DATA_BYTES = 16,
   parameter int ROUND      = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_en,
   input  logic [BYTE_W-1:0]            iot_in,
   input  logic [2:0]                   fn_sel,
   input  logic [BYTE_W*DATA_BYTES-1:0] lo_th,
   input  logic [BYTE_W*DATA_BYTES-1:0] hi_th,
   input  logic                         out_ready,
   output logic                         busy,
   output logic                         valid,
   output logic [BYTE_W*DATA_BYTES-1:0] iot_out
);

   localparam int W    = BYTE_W * DATA_BYTES;
   localparam int LG   = $clog2(ROUND);
   localparam int BC_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam int SH_W = (DATA_BYTES > 1) ? (W - BYTE_W) : W;

   localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(DATA_BYTES - 1);
   localparam logic [LG-1:0]   ITEM_LAST = LG'(ROUND - 1);

   localparam logic [2:0] FN_MAX  = 3'd1;
   localparam logic [2:0] FN_MIN  = 3'd2;
   localparam logic [2:0] FN_AVG  = 3'd3;
   localparam logic [2:0] FN_EXT  = 3'd4;
   localparam logic [2:0] FN_EXC  = 3'd5;
   localparam logic [2:0] FN_PMAX = 3'd6;
   localparam logic [2:0] FN_PMIN = 3'd7;

   logic [BC_W-1:0] beat_cnt_r;
   logic [LG-1:0]   item_cnt_r;
   logic [SH_W-1:0] item_r;
   logic [W+LG-1:0] acc_r;
   logic [W-1:0]    peak_r;
   logic            peak_empty_r;
   logic [2:0]      fn_r;
   logic            valid_r;
   logic [W-1:0]    out_r;

   logic            busy_s;
   logic            accept_s;
   logic            item_done_s;
   logic            round_start_s;
   logic            first_item_s;
   logic            last_item_s;
   logic [2:0]      fn_eff_s;
   logic            peak_empty_s;
   logic [W-1:0]    item_next_s;
   logic [W+LG-1:0] item_ext_s;
   logic [W+LG-1:0] max_next_s;
   logic [W+LG-1:0] min_next_s;
   logic [W+LG-1:0] sum_next_s;
   logic [W+LG-1:0] acc_next_s;
   logic            load_s;
   logic [W-1:0]    res_s;
   logic            peak_load_s;
   logic [W-1:0]    peak_next_s;

   generate
      if (DATA_BYTES > 1) begin : g_shift
         assign item_next_s = {item_r, iot_in};
      end else begin : g_single
         assign item_next_s = iot_in;
      end
   endgenerate

   assign busy_s        = valid_r && !out_ready;
   assign accept_s      = in_en && !busy_s;
   assign item_done_s   = accept_s && (beat_cnt_r == BEAT_LAST);
   assign round_start_s = accept_s && (beat_cnt_r == '0) && (item_cnt_r == '0);
   assign first_item_s  = (item_cnt_r == '0);
   assign last_item_s   = (item_cnt_r == ITEM_LAST);
   // With one-beat items the round's first beat also completes an item, so use fn_sel directly.
   assign fn_eff_s      = round_start_s ? fn_sel : fn_r;
   assign peak_empty_s  = peak_empty_r || (round_start_s && (fn_sel != fn_r));

   assign item_ext_s = {{LG{1'b0}}, item_next_s};
   assign max_next_s = (first_item_s || (item_next_s > acc_r[W-1:0])) ? item_ext_s : acc_r;
   assign min_next_s = (first_item_s || (item_next_s < acc_r[W-1:0])) ? item_ext_s : acc_r;
   assign sum_next_s = first_item_s ? item_ext_s : (acc_r + item_ext_s);

   // Result selection and peak update for the item completing this cycle
   always_comb begin
      acc_next_s  = acc_r;
      load_s      = 1'b0;
      res_s       = item_next_s;
      peak_load_s = 1'b0;
      peak_next_s = item_next_s;
      if (item_done_s) begin
         case (fn_eff_s)
            FN_MAX: begin
               acc_next_s = max_next_s;
               load_s     = last_item_s;
               res_s      = max_next_s[W-1:0];
            end
            FN_MIN: begin
               acc_next_s = min_next_s;
               load_s     = last_item_s;
               res_s      = min_next_s[W-1:0];
            end
            FN_AVG: begin
               acc_next_s = sum_next_s;
               load_s     = last_item_s;
               res_s      = sum_next_s[W+LG-1:LG];
            end
            FN_EXT: begin
               load_s = (item_next_s > lo_th) && (item_next_s < hi_th);
            end
            FN_EXC: begin
               load_s = (item_next_s < lo_th) || (item_next_s > hi_th);
            end
            FN_PMAX: begin
               if (peak_empty_s) begin
                  acc_next_s  = max_next_s;
                  load_s      = last_item_s;
                  res_s       = max_next_s[W-1:0];
                  peak_load_s = last_item_s;
                  peak_next_s = max_next_s[W-1:0];
               end else begin
                  load_s      = item_next_s > peak_r;
                  peak_load_s = item_next_s > peak_r;
               end
            end
            FN_PMIN: begin
               if (peak_empty_s) begin
                  acc_next_s  = min_next_s;
                  load_s      = last_item_s;
                  res_s       = min_next_s[W-1:0];
                  peak_load_s = last_item_s;
                  peak_next_s = min_next_s[W-1:0];
               end else begin
                  load_s      = item_next_s < peak_r;
                  peak_load_s = item_next_s < peak_r;
               end
            end
            default: begin
               load_s = 1'b0;
            end
         endcase
      end else begin
         load_s = 1'b0;
      end
   end

   // Beat/item counters and the partial-item shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_r <= '0;
         item_cnt_r <= '0;
         item_r     <= '0;
      end else if (accept_s) begin
         item_r <= item_next_s[SH_W-1:0];
         if (beat_cnt_r == BEAT_LAST) begin
            beat_cnt_r <= '0;
            item_cnt_r <= (item_cnt_r == ITEM_LAST) ? '0 : item_cnt_r + 1'b1;
         end else begin
            beat_cnt_r <= beat_cnt_r + 1'b1;
         end
      end
   end

   // Round accumulator (running max/min/sum)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= '0;
      end else if (item_done_s) begin
         acc_r <= acc_next_s;
      end
   end

   // Latched round function and persistent peak
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fn_r         <= 3'd0;
         peak_r       <= '0;
         peak_empty_r <= 1'b1;
      end else begin
         if (round_start_s) begin
            fn_r <= fn_sel;
         end
         if (peak_load_s) begin
            peak_r       <= peak_next_s;
            peak_empty_r <= 1'b0;
         end else if (round_start_s && (fn_sel != fn_r)) begin
            peak_empty_r <= 1'b1;
         end
      end
   end

   // One-entry output holding register; a new load wins over a simultaneous consume
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= 1'b0;
         out_r   <= '0;
      end else if (load_s) begin
         valid_r <= 1'b1;
         out_r   <= res_s;
      end else if (out_ready) begin
         valid_r <= 1'b0;
      end
   end

   assign busy    = busy_s;
   assign valid   = valid_r;
   assign iot_out = out_r;

endmodule

// File: tb/tb_iot_stream_filter.sv
// Scoreboard bench for iot_stream_filter: a reference model pushes expected results,
// a negedge monitor pops them whenever the DUT hands an item to the sink.
module tb_iot_stream_filter;

   localparam int BYTE_W     = 8;
   localparam int DATA_BYTES = 16;
   localparam int ROUND      = 8;
   localparam int W          = BYTE_W * DATA_BYTES;

   typedef logic [W-1:0] item_arr_t [ROUND];

   logic              clk;
   logic              rst;
   logic              in_en;
   logic [BYTE_W-1:0] iot_in;
   logic [2:0]        fn_sel;
   logic [W-1:0]      lo_th;
   logic [W-1:0]      hi_th;
   logic              out_ready;
   logic              busy;
   logic              valid;
   logic [W-1:0]      iot_out;

   int           checks;
   int           failures;
   logic [W-1:0] exp_q [$];
   logic [2:0]   m_fn_prev;
   logic [W-1:0] m_peak;
   logic         m_peak_empty;
   item_arr_t    arr;

   iot_stream_filter #(
      .BYTE_W    (BYTE_W),
      .DATA_BYTES(DATA_BYTES),
      .ROUND     (ROUND)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_en    (in_en),
      .iot_in   (iot_in),
      .fn_sel   (fn_sel),
      .lo_th    (lo_th),
      .hi_th    (hi_th),
      .out_ready(out_ready),
      .busy     (busy),
      .valid    (valid),
      .iot_out  (iot_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every cycle the sink takes an item, it must match the head of the queue
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst && valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got=%0h want=none", iot_out);
         end else begin
            e = exp_q.pop_front();
            if (iot_out !== e) begin
               failures++;
               $display("FAIL sb_value got=%0h want=%0h", iot_out, e);
            end
         end
      end
   end

   task automatic send_item(input logic [W-1:0] v, input logic emit, input logic [W-1:0] expv,
                            input int skip);
      if (emit) exp_q.push_back(expv);
      for (int b = skip; b < DATA_BYTES; b++) begin
         in_en  = 1'b1;
         iot_in = v[W-1-BYTE_W*b -: BYTE_W];
         @(posedge clk);
         #1;
      end
      in_en = 1'b0;
      checks++;
      if (valid !== emit) begin
         failures++;
         $display("FAIL item_valid item=%0h got=%0b want=%0b", v, valid, emit);
      end
   endtask

   task automatic run_round(input logic [2:0] fn, input item_arr_t it, input int skip);
      logic [W-1:0] mx, mn, res;
      logic [W+2:0] sum;
      logic         empty_at_start, emit;
      mx  = it[0];
      mn  = it[0];
      sum = '0;
      for (int i = 0; i < ROUND; i++) begin
         if (it[i] > mx) mx = it[i];
         if (it[i] < mn) mn = it[i];
         sum = sum + {3'b000, it[i]};
      end
      if (fn != m_fn_prev) m_peak_empty = 1'b1;
      m_fn_prev      = fn;
      empty_at_start = m_peak_empty;
      fn_sel         = fn;
      for (int i = 0; i < ROUND; i++) begin
         emit = 1'b0;
         res  = it[i];
         case (fn)
            3'd1: begin emit = (i == ROUND-1); res = mx; end
            3'd2: begin emit = (i == ROUND-1); res = mn; end
            3'd3: begin emit = (i == ROUND-1); res = sum[W+2:3]; end
            3'd4: emit = (it[i] > lo_th) && (it[i] < hi_th);
            3'd5: emit = (it[i] < lo_th) || (it[i] > hi_th);
            3'd6: begin
               if (empty_at_start) begin
                  emit = (i == ROUND-1);
                  res  = mx;
                  if (emit) begin m_peak = mx; m_peak_empty = 1'b0; end
               end else if (it[i] > m_peak) begin
                  emit   = 1'b1;
                  m_peak = it[i];
               end
            end
            3'd7: begin
               if (empty_at_start) begin
                  emit = (i == ROUND-1);
                  res  = mn;
                  if (emit) begin m_peak = mn; m_peak_empty = 1'b0; end
               end else if (it[i] < m_peak) begin
                  emit   = 1'b1;
                  m_peak = it[i];
               end
            end
            default: emit = 1'b0;
         endcase
         send_item(it[i], emit, res, (i == 0) ? skip : 0);
         if (i == 0) fn_sel = fn ^ 3'b111;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || iot_out !== '0) begin
         failures++;
         $display("FAIL reset_state got valid=%0b busy=%0b out=%0h want 0/0/0", valid, busy, iot_out);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_max();
      arr = '{128'd5, 128'd9, 128'd3, 128'd200, 128'd7, 128'd1, 128'd0, 128'd4};
      run_round(3'd1, arr, 0);
   endtask

   task automatic test_avg();
      for (int i = 0; i < ROUND; i++) arr[i] = {W{1'b1}};
      run_round(3'd3, arr, 0);
      for (int i = 0; i < ROUND; i++) arr[i] = W'(i + 1);
      run_round(3'd3, arr, 0);
   endtask

   task automatic test_ext_exc();
      lo_th = 128'd10;
      hi_th = 128'd20;
      arr = '{128'd10, 128'd11, 128'd19, 128'd20, 128'd15, 128'd5, 128'd25, 128'd12};
      run_round(3'd4, arr, 0);
      arr = '{128'd9, 128'd10, 128'd20, 128'd21, 128'd0, 128'd15, 128'd255, 128'd11};
      run_round(3'd5, arr, 0);
   endtask

   task automatic test_peaks();
      arr = '{128'd10, 128'd50, 128'd3, 128'd20, 128'd49, 128'd1, 128'd0, 128'd7};
      run_round(3'd6, arr, 0);
      arr = '{128'd40, 128'd60, 128'd60, 128'd55, 128'd70, 128'd1, 128'd2, 128'd3};
      run_round(3'd6, arr, 0);
      arr = '{128'd100, 128'd80, 128'd90, 128'd120, 128'd85, 128'd200, 128'd81, 128'd95};
      run_round(3'd7, arr, 0);
      arr = '{128'd90, 128'd70, 128'd70, 128'd75, 128'd60, 128'd200, 128'd60, 128'd61};
      run_round(3'd7, arr, 0);
   endtask

   task automatic test_fn0();
      arr = '{128'd1, 128'd2, 128'd3, 128'd4, 128'd5, 128'd6, 128'd7, 128'd8};
      run_round(3'd0, arr, 0);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] pend;
      out_ready = 1'b0;
      arr = '{128'd33, 128'd17, 128'd44, 128'd21, 128'd90, 128'd18, 128'd25, 128'd30};
      run_round(3'd2, arr, 0);
      pend   = exp_q[0];
      arr    = '{{8'hA5, 120'd0}, 128'd6, 128'd9, 128'd8, 128'd7, 128'd12, 128'd6, 128'd11};
      fn_sel = 3'd2;
      in_en  = 1'b1;
      iot_in = 8'hA5;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (busy !== 1'b1 || valid !== 1'b1 || iot_out !== pend) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got busy=%0b valid=%0b out=%0h want 1/1/%0h",
                     c, busy, valid, iot_out, pend);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release got valid=%0b want 0", valid);
      end
      run_round(3'd2, arr, 1);
   endtask

   task automatic test_reset_mid_round();
      fn_sel = 3'd1;
      for (int b = 0; b < 70; b++) begin
         in_en  = 1'b1;
         iot_in = 8'hFF;
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || iot_out !== '0) begin
         failures++;
         $display("FAIL reset_mid got valid=%0b busy=%0b out=%0h want 0/0/0", valid, busy, iot_out);
      end
      in_en = 1'b0;
      exp_q.delete();
      m_fn_prev    = 3'd0;
      m_peak_empty = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < ROUND; i++) arr[i] = 128'd3;
      run_round(3'd1, arr, 0);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      in_en        = 1'b0;
      iot_in       = 8'h00;
      fn_sel       = 3'd0;
      lo_th        = '0;
      hi_th        = '0;
      out_ready    = 1'b1;
      m_fn_prev    = 3'd0;
      m_peak       = '0;
      m_peak_empty = 1'b1;

      test_reset();
      test_max();
      test_avg();
      test_ext_exc();
      test_peaks();
      test_fn0();
      test_backpressure();
      test_reset_mid_round();

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got=%0d pending want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
